// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction fetch path:
//   INST_NOP          - canonical NOP (addi x0, x0, 0) shown when no instruction
//   RESET_PC_DEFAULT  - default first fetch address after reset
//   ifu_state_e       - fetch FSM state encodings
//   fetch_entry_t     - one buffered instruction together with its address
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,  // no request on the bus
        IFU_REQ  = 2'd1,  // mem_req_o high, waiting for grant
        IFU_WAIT = 2'd2   // one request granted, waiting for read data
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// -----------------------------------------------------------------------------
// ifetch_unit_if
// Instruction memory request/response bus between the fetch unit and memory.
//   mem_req_o    - fetch request (driven by fetch unit)
//   mem_addr_o   - word-aligned fetch address (driven by fetch unit)
//   mem_gnt_i    - request accepted this cycle (driven by memory)
//   mem_rvalid_i - read data valid (driven by memory)
//   mem_rdata_i  - read data (driven by memory)
// Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface ifetch_unit_if;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/ifu_fifo.sv
// -----------------------------------------------------------------------------
// ifu_fifo
// Small synchronous FIFO buffering fetched instructions with their addresses.
//   clk, rst   - clock, synchronous active-high reset
//   flush      - empty the buffer this cycle (wins over push/pop)
//   push       - write push_data (accepted when not full, or full with a pop)
//   push_data  - entry to write
//   pop        - remove the head entry (ignored when empty)
//   head       - oldest entry, meaningful only when !empty
//   full/empty - occupancy flags
//   count      - current number of entries
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ifu_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch unit: issues one word fetch at a time to instruction memory,
// buffers responses in ifu_fifo and hands them to if_id with a valid/ready
// handshake. Supports redirect (jump) with flush and pipeline hold.
//   clk, rst          - clock, synchronous active-high reset
//   jump_en_i         - redirect request; jump_addr_i is the target
//   hold_flag_i       - pipeline stall: hides output, blocks pops and new fetches
//   mem               - instruction memory bus (ifetch_unit_if.master)
//   inst_valid_o      - instruction available; inst_o / inst_addr_o describe it
//   inst_ready_i      - if_id accepts the instruction
//   addr_misalign_o   - one-cycle pulse after a jump to a non-word-aligned target
// Parameters: RESET_PC (first fetch address), FIFO_DEPTH (2 or 4).
// Build option: define IFU_MISALIGN_CHK_EN to enable the misaligned-jump check;
// otherwise addr_misalign_o is constant 0.
// -----------------------------------------------------------------------------
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jump_en_i,
    input  logic [31:0]          jump_addr_i,
    input  logic                 hold_flag_i,
    ifetch_unit_if.master        mem,
    output logic                 inst_valid_o,
    output logic [31:0]          inst_o,
    output logic [31:0]          inst_addr_o,
    input  logic                 inst_ready_i,
    output logic                 addr_misalign_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    ifu_state_e       state;
    logic [31:0]      pc;         // next address to request
    logic [31:0]      req_addr;   // address of the granted, outstanding request
    logic             discard;    // outstanding response belongs to a flushed stream
    logic             mem_req;

    logic [31:0]      jump_pc;
    logic             accept;
    logic             pop_fire;
    logic             idle_space;
    logic             wait_space;

    fetch_entry_t     push_data;
    fetch_entry_t     head;
    logic             fifo_empty;
    logic             unused_fifo_full;
    logic [CNT_W-1:0] fifo_count;

    assign jump_pc = {jump_addr_i[31:2], 2'b00};

    // A response is kept only if it answers a live request and no redirect
    // is happening in the same cycle.
    assign accept = (state == IFU_WAIT) && mem.mem_rvalid_i && !discard && !jump_en_i;

    assign inst_valid_o = !fifo_empty && !hold_flag_i && !jump_en_i;
    assign pop_fire     = inst_valid_o && inst_ready_i;
    assign inst_o       = fifo_empty ? INST_NOP : head.data;
    assign inst_addr_o  = fifo_empty ? 32'h0    : head.addr;

    // Room checks count the outstanding request as an occupied slot.
    // In IDLE nothing is outstanding; in WAIT the arriving response takes a
    // slot, so another fetch fits if one more slot is free or the head leaves.
    assign idle_space = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign wait_space = pop_fire || (fifo_count < CNT_W'(FIFO_DEPTH - 1));

    assign push_data = '{addr: req_addr, data: mem.mem_rdata_i};

    assign mem.mem_req_o  = mem_req;
    assign mem.mem_addr_o = pc;

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_en_i),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop_fire),
        .head      (head),
        .full      (unused_fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IFU_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
            mem_req  <= 1'b0;
        end else begin
            case (state)
                IFU_IDLE: begin
                    if (jump_en_i) begin
                        pc      <= jump_pc;
                        state   <= IFU_REQ;
                        mem_req <= 1'b1;
                    end else if (!hold_flag_i && idle_space) begin
                        state   <= IFU_REQ;
                        mem_req <= 1'b1;
                    end
                end

                IFU_REQ: begin
                    if (mem.mem_gnt_i) begin
                        // A grant coinciding with a jump still leaves a request
                        // in flight; its data is marked for discard.
                        req_addr <= pc;
                        pc       <= jump_en_i ? jump_pc : pc + 32'd4;
                        discard  <= jump_en_i;
                        state    <= IFU_WAIT;
                        mem_req  <= 1'b0;
                    end else if (jump_en_i) begin
                        pc <= jump_pc;
                    end
                end

                IFU_WAIT: begin
                    if (jump_en_i) begin
                        pc <= jump_pc;
                    end
                    if (mem.mem_rvalid_i) begin
                        discard <= 1'b0;
                        // After a redirect the buffer is empty, so refetch at once.
                        if (jump_en_i || discard || wait_space) begin
                            state   <= IFU_REQ;
                            mem_req <= 1'b1;
                        end else begin
                            state   <= IFU_IDLE;
                            mem_req <= 1'b0;
                        end
                    end else if (jump_en_i) begin
                        // Keep waiting so only one request is ever outstanding.
                        discard <= 1'b1;
                    end
                end

                default: begin
                    state   <= IFU_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= jump_en_i && (jump_addr_i[1:0] != 2'b00);
        end
    end

    assign addr_misalign_o = misalign_q;
`else
    logic unused_jump_lsb;

    assign unused_jump_lsb = ^jump_addr_i[1:0];
    assign addr_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
// Directed self-checking bench for ifetch_unit (FIFO_DEPTH=2, RESET_PC=0).
// Memory is modelled inline: gnt always high, and when auto_resp is set the
// response arrives the cycle after a grant with data {16'hC0DE, addr[15:0]}.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;
    import riscv_pkg::*;

`ifdef IFU_MISALIGN_CHK_EN
    localparam logic [31:0] EXP_MISALIGN = 32'd1;
`else
    localparam logic [31:0] EXP_MISALIGN = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;
    logic        addr_misalign_o;

    int checks    = 0;
    int failures  = 0;
    int grant_cnt = 0;
    bit auto_resp = 1'b1;

    ifetch_unit_if mem_if ();

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .jump_en_i       (jump_en_i),
        .jump_addr_i     (jump_addr_i),
        .hold_flag_i     (hold_flag_i),
        .mem             (mem_if),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_addr_o     (inst_addr_o),
        .inst_ready_i    (inst_ready_i),
        .addr_misalign_o (addr_misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle; inputs change and outputs are sampled 1 time unit after
    // the rising edge. The inline memory answers grants seen before the edge.
    task automatic tick();
        logic        gnt_seen;
        logic [31:0] addr_seen;
        gnt_seen  = mem_if.mem_req_o && mem_if.mem_gnt_i;
        addr_seen = mem_if.mem_addr_o;
        @(posedge clk);
        #1;
        if (gnt_seen) grant_cnt++;
        if (auto_resp) begin
            mem_if.mem_rvalid_i = gnt_seen;
            mem_if.mem_rdata_i  = gnt_seen ? {16'hC0DE, addr_seen[15:0]} : 32'h0;
        end
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        jump_en_i           = 1'b0;
        hold_flag_i         = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        auto_resp           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a valid instruction and checks its address and data.
    task automatic expect_inst(input string tag, input logic [31:0] addr, input logic [31:0] data);
        for (int n = 0; n < 20 && !inst_valid_o; n++) tick();
        check({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd1);
        check({tag, "_addr"}, inst_addr_o, addr);
        check({tag, "_data"}, inst_o, data);
    endtask

    initial begin
        rst                 = 1'b1;
        jump_en_i           = 1'b0;
        jump_addr_i         = 32'h0;
        hold_flag_i         = 1'b0;
        inst_ready_i        = 1'b1;
        mem_if.mem_gnt_i    = 1'b1;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = 32'h0;

        // Reset values.
        tick();
        tick();
        check("rst_req",      {31'd0, mem_if.mem_req_o}, 32'd0);
        check("rst_addr",     mem_if.mem_addr_o, 32'h0000_0000);
        check("rst_valid",    {31'd0, inst_valid_o}, 32'd0);
        check("rst_inst",     inst_o, 32'h0000_0013);
        check("rst_inst_addr", inst_addr_o, 32'h0000_0000);
        check("rst_misalign", {31'd0, addr_misalign_o}, 32'd0);

        // Basic sequence 0,4,8 with exact first-fetch timing.
        rst = 1'b0;
        tick();
        check("first_req",  {31'd0, mem_if.mem_req_o}, 32'd1);
        check("first_addr", mem_if.mem_addr_o, 32'h0000_0000);
        tick();
        check("rvalid_cycle_valid", {31'd0, inst_valid_o}, 32'd0);
        check("after_gnt_req",      {31'd0, mem_if.mem_req_o}, 32'd0);
        tick();
        check("lat1_valid", {31'd0, inst_valid_o}, 32'd1);
        check("lat1_addr",  inst_addr_o, 32'h0000_0000);
        check("lat1_data",  inst_o, 32'hC0DE_0000);
        tick();
        expect_inst("seq4", 32'h0000_0004, 32'hC0DE_0004);
        tick();
        expect_inst("seq8", 32'h0000_0008, 32'hC0DE_0008);

        // Backpressure: only FIFO_DEPTH fetches, then the bus goes quiet.
        inst_ready_i = 1'b0;
        do_reset();
        grant_cnt = 0;
        for (int i = 0; i < 12; i++) tick();
        check("stall_grants", grant_cnt, 32'd2);
        check("stall_req",    {31'd0, mem_if.mem_req_o}, 32'd0);
        inst_ready_i = 1'b1;
        #1;
        expect_inst("stall_e0", 32'h0000_0000, 32'hC0DE_0000);
        tick();
        expect_inst("stall_e1", 32'h0000_0004, 32'hC0DE_0004);
        tick();
        expect_inst("stall_e2", 32'h0000_0008, 32'hC0DE_0008);

        // Jump while WAIT: old response dropped, refetch at 0x100.
        do_reset();
        auto_resp = 1'b0;
        tick();
        tick();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0100;
        #1;
        check("jump_valid_low", {31'd0, inst_valid_o}, 32'd0);
        tick();
        jump_en_i = 1'b0;
        check("jwait_req_low", {31'd0, mem_if.mem_req_o}, 32'd0);
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = 32'hDEAD_0000;
        tick();
        mem_if.mem_rvalid_i = 1'b0;
        check("jwait_dropped", {31'd0, inst_valid_o}, 32'd0);
        check("jwait_req",     {31'd0, mem_if.mem_req_o}, 32'd1);
        check("jwait_addr",    mem_if.mem_addr_o, 32'h0000_0100);
        auto_resp = 1'b1;
        expect_inst("jwait_inst", 32'h0000_0100, 32'hC0DE_0100);

        // Jump and rvalid in the same cycle: response dropped.
        do_reset();
        auto_resp = 1'b0;
        tick();
        tick();
        jump_en_i           = 1'b1;
        jump_addr_i         = 32'h0000_0300;
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = 32'hBAD0_0000;
        tick();
        jump_en_i           = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        check("jrv_valid", {31'd0, inst_valid_o}, 32'd0);
        check("jrv_req",   {31'd0, mem_if.mem_req_o}, 32'd1);
        check("jrv_addr",  mem_if.mem_addr_o, 32'h0000_0300);
        auto_resp = 1'b1;
        expect_inst("jrv_inst", 32'h0000_0300, 32'hC0DE_0300);

        // Hold with two entries buffered: hidden, not popped, then in order.
        inst_ready_i = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        hold_flag_i  = 1'b1;
        inst_ready_i = 1'b1;
        #1;
        check("hold_valid", {31'd0, inst_valid_o}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("hold_valid_late", {31'd0, inst_valid_o}, 32'd0);
        hold_flag_i = 1'b0;
        #1;
        expect_inst("hold_e0", 32'h0000_0000, 32'hC0DE_0000);
        tick();
        expect_inst("hold_e1", 32'h0000_0004, 32'hC0DE_0004);

        // Hold blocks fetch from IDLE; jump wins over hold; misaligned target.
        do_reset();
        hold_flag_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("hold_idle_req", {31'd0, mem_if.mem_req_o}, 32'd0);
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0102;
        tick();
        jump_en_i = 1'b0;
        check("jhold_req",      {31'd0, mem_if.mem_req_o}, 32'd1);
        check("jhold_addr",     mem_if.mem_addr_o, 32'h0000_0100);
        check("misalign_pulse", {31'd0, addr_misalign_o}, EXP_MISALIGN);
        tick();
        check("misalign_clear", {31'd0, addr_misalign_o}, 32'd0);
        tick();
        tick();
        check("jhold_hidden", {31'd0, inst_valid_o}, 32'd0);
        hold_flag_i = 1'b0;
        #1;
        expect_inst("jhold_inst", 32'h0000_0100, 32'hC0DE_0100);

        // Fetch PC wraps from 0xFFFF_FFFC to 0.
        do_reset();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'hFFFF_FFFC;
        tick();
        jump_en_i = 1'b0;
        expect_inst("wrap_top", 32'hFFFF_FFFC, 32'hC0DE_FFFC);
        tick();
        expect_inst("wrap_zero", 32'h0000_0000, 32'hC0DE_0000);

        // Reset while WAIT; late rvalid ignored, fetch restarts at RESET_PC.
        do_reset();
        auto_resp = 1'b0;
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0040;
        tick();
        jump_en_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst                 = 1'b0;
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = 32'hBAD0_0040;
        tick();
        mem_if.mem_rvalid_i = 1'b0;
        check("rstw_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rstw_req",   {31'd0, mem_if.mem_req_o}, 32'd1);
        check("rstw_addr",  mem_if.mem_addr_o, 32'h0000_0000);
        auto_resp = 1'b1;
        expect_inst("rstw_inst", 32'h0000_0000, 32'hC0DE_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
